// File: rtl/crc_decode_controller.sv
// Sequencer for a serial CRC-4 decoder: accepts one codeword, steps the decoder
// through load/shift/complete, then holds the captured result for the consumer.
module crc_decode_controller #(
   parameter int unsigned CODE_WIDTH    = 12,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CODE_WIDTH-1:0]    in_code,
   output logic [CODE_WIDTH-1:0]    dec_encoded_data,
   output logic                     dec_load,
   output logic                     dec_shift_en,
   output logic                     dec_processing_complete,
   input  logic [DATA_WIDTH-1:0]    dec_decoded_data,
   input  logic                     dec_error_detected,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_error,
   output logic                     busy,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   input  logic                     err_clr
);

   localparam int unsigned CNT_W = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1;
   localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(CODE_WIDTH - 1);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      CHECK,
      DONE
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             accept;

   assign accept = (state == IDLE) && in_valid && in_ready;

   // Next-state and shift-count logic
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (accept) state_n = LOAD;
         end
         LOAD: begin
            cnt_n   = '0;
            state_n = SHIFT;
         end
         SHIFT: begin
            if (cnt == CNT_LAST) state_n = CHECK;
            else                 cnt_n   = cnt + CNT_W'(1);
         end
         CHECK: begin
            state_n = DONE;
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // State register; strobes are registered from the next state so they align with it
   always_ff @(posedge clk) begin
      if (rst) begin
         state                   <= IDLE;
         cnt                     <= '0;
         in_ready                <= 1'b0;
         dec_load                <= 1'b0;
         dec_shift_en            <= 1'b0;
         dec_processing_complete <= 1'b0;
         out_valid               <= 1'b0;
         busy                    <= 1'b0;
      end else begin
         state                   <= state_n;
         cnt                     <= cnt_n;
         in_ready                <= (state_n == IDLE);
         dec_load                <= (state_n == LOAD);
         dec_shift_en            <= (state_n == SHIFT);
         dec_processing_complete <= (state_n == CHECK);
         out_valid               <= (state_n == DONE);
         busy                    <= (state_n != IDLE);
      end
   end

   // Codeword capture, result capture and saturating error count
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_encoded_data <= '0;
         out_data         <= '0;
         out_error        <= 1'b0;
         err_count        <= '0;
      end else begin
         if (accept) dec_encoded_data <= in_code;
         if (state == CHECK) begin
            out_data  <= dec_decoded_data;
            out_error <= dec_error_detected;
         end
         if (err_clr) begin
            err_count <= '0;
         end else if ((state == CHECK) && dec_error_detected && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_crc_decode_controller.sv
// Directed-plus-random bench for crc_decode_controller with a behavioural
// CRC-4 decoder stand-in and an arithmetic reference for results and error count.
module tb_crc_decode_controller;

   localparam int unsigned CW  = 12;
   localparam int unsigned DW  = 8;
   localparam int unsigned ECW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [CW-1:0]  in_code;
   logic [CW-1:0]  dec_encoded_data;
   logic           dec_load;
   logic           dec_shift_en;
   logic           dec_processing_complete;
   logic [DW-1:0]  dec_decoded_data;
   logic           dec_error_detected;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_data;
   logic           out_error;
   logic           busy;
   logic [ECW-1:0] err_count;
   logic           err_clr;

   int checks   = 0;
   int passed   = 0;
   int fails    = 0;
   int cyc      = 0;
   int exp_cnt  = 0;
   int prev_acc = -1;
   bit stream   = 1'b0;

   crc_decode_controller #(
      .CODE_WIDTH   (CW),
      .DATA_WIDTH   (DW),
      .ERR_CNT_WIDTH(ECW)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .in_valid               (in_valid),
      .in_ready               (in_ready),
      .in_code                (in_code),
      .dec_encoded_data       (dec_encoded_data),
      .dec_load               (dec_load),
      .dec_shift_en           (dec_shift_en),
      .dec_processing_complete(dec_processing_complete),
      .dec_decoded_data       (dec_decoded_data),
      .dec_error_detected     (dec_error_detected),
      .out_valid              (out_valid),
      .out_ready              (out_ready),
      .out_data               (out_data),
      .out_error              (out_error),
      .busy                   (busy),
      .err_count              (err_count),
      .err_clr                (err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Polynomial long division by x^4+x+1 over the whole codeword
   function automatic logic [3:0] crc_rem(input logic [11:0] cw);
      logic [11:0] r;
      r = cw;
      for (int i = 11; i >= 4; i--) begin
         if (r[i]) r = r ^ (12'h013 << (i - 4));
      end
      return r[3:0];
   endfunction

   // Decoder stand-in: the true result only while processing_complete is high
   always_comb begin
      if (dec_processing_complete) begin
         dec_decoded_data   = dec_encoded_data[11:4];
         dec_error_detected = (crc_rem(dec_encoded_data) != 4'h0);
      end else begin
         dec_decoded_data   = ~dec_encoded_data[11:4];
         dec_error_detected = (crc_rem(dec_encoded_data) == 4'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] make_word(input bit bad);
      logic [7:0]  d;
      logic [11:0] w;
      d = 8'($urandom);
      w = {d, crc_rem({d, 4'h0})};
      if (bad) w = w ^ (12'h001 << $urandom_range(0, 11));
      return w;
   endfunction

   // One full transaction; hold = DONE cycles with out_ready low, clr = err_clr at CHECK
   task automatic run_word(input logic [11:0] code, input int hold, input bit clr);
      int         n = 0;
      logic [7:0] ed;
      logic       ee;
      ed = code[11:4];
      ee = (crc_rem(code) != 4'h0);
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      check("accept_ready", in_ready, 1);
      in_valid  = 1'b1;
      in_code   = code;
      out_ready = (hold == 0);
      tick();
      if (stream && prev_acc >= 0) check("accept_spacing", cyc - prev_acc, 16);
      prev_acc = cyc;
      if (!stream) in_valid = 1'b0;
      check("enc_data", dec_encoded_data, code);
      for (int c = 1; c <= 14; c++) begin
         check("load", dec_load, c == 1);
         check("shift", dec_shift_en, (c >= 2) && (c <= 13));
         check("complete", dec_processing_complete, c == 14);
         check("strobe_onehot", $countones({dec_load, dec_shift_en, dec_processing_complete}) <= 1, 1);
         check("busy", busy, 1);
         check("in_ready_busy", in_ready, 0);
         check("out_valid_early", out_valid, 0);
         if (c == 14) err_clr = clr;
         tick();
         err_clr = 1'b0;
      end
      if (clr)                                exp_cnt = 0;
      else if (ee && exp_cnt < (1 << ECW) - 1) exp_cnt++;
      check("out_valid", out_valid, 1);
      check("out_data", out_data, ed);
      check("out_error", out_error, ee);
      check("err_count", err_count, exp_cnt);
      check("strobes_done", {dec_load, dec_shift_en, dec_processing_complete}, 0);
      if (hold > 0) begin
         in_valid = 1'b1;
         in_code  = 12'($urandom);
         for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, ed);
            check("hold_error", out_error, ee);
            check("hold_in_ready", in_ready, 0);
         end
         in_valid  = stream;
         in_code   = code;
         out_ready = 1'b1;
      end
      tick();
      check("post_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
      check("enc_hold", dec_encoded_data, code);
      in_valid = stream;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_code   = '0;
      out_ready = 1'b0;
      err_clr   = 1'b0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_strobes", {dec_load, dec_shift_en, dec_processing_complete}, 0);
      check("rst_out", {out_valid, out_error, out_data}, 0);
      check("rst_busy", busy, 0);
      check("rst_err_count", err_count, 0);
      check("rst_enc", dec_encoded_data, 0);
      rst = 1'b0;

      run_word(12'h013, 0, 1'b0);
      run_word(12'hFF4, 0, 1'b0);
      run_word(12'hFF5, 20, 1'b0);

      // Abort in the middle of SHIFT
      in_valid = 1'b1;
      in_code  = 12'h0A5;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      check("shift_before_rst", dec_shift_en, 1);
      rst = 1'b1;
      tick();
      check("abort_strobes", {dec_load, dec_shift_en, dec_processing_complete}, 0);
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_err_count", err_count, 0);
      exp_cnt = 0;
      rst     = 1'b0;
      run_word(12'h013, 0, 1'b0);

      for (int i = 0; i < 5; i++) run_word(make_word(1'b1), 0, 1'b0);
      check("saturated", err_count, 3);
      run_word(make_word(1'b1), 0, 1'b1);
      check("clr_priority", err_count, 0);

      stream   = 1'b1;
      prev_acc = -1;
      for (int i = 0; i < 6; i++) run_word(make_word(1'($urandom)), 0, 1'b0);
      stream   = 1'b0;
      in_valid = 1'b0;

      for (int i = 0; i < 20; i++) begin
         run_word(make_word(1'($urandom)), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/crc_decode_controller.md
Name: crc_decode_controller

Overview:
- Sequences the 12-bit CRC-4 decoder datapath (polynomial x^4+x+1, 8 data bits + 4 check bits) for one codeword at a time.
- Accepts codewords from a requester over a valid/ready handshake and drives the decoder's load, shift_en and processing_complete strobes in order.
- Captures decoded data and the error flag, then presents the result on a valid/ready output handshake.
- Keeps a saturating count of failed codewords for status readout.

Parameters:
- CODE_WIDTH, 12, codeword bits; equals the number of shift cycles per codeword.
- DATA_WIDTH, 8, payload bits returned by the decoder.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  requester presents a codeword.
- in_ready  output  1  controller can accept a codeword.
- in_code  input  CODE_WIDTH  codeword from the requester.
- dec_encoded_data  output  CODE_WIDTH  registered codeword driven to the decoder.
- dec_load  output  1  decoder load strobe.
- dec_shift_en  output  1  decoder shift enable.
- dec_processing_complete  output  1  end-of-codeword strobe to the decoder.
- dec_decoded_data  input  DATA_WIDTH  decoder payload.
- dec_error_detected  input  1  decoder nonzero-remainder flag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_WIDTH  captured payload.
- out_error  output  1  captured error flag.
- busy  output  1  high in every state except IDLE.
- err_count  output  ERR_CNT_WIDTH  saturating count of codewords with out_error=1.
- err_clr  input  1  synchronous clear of err_count.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, shift counter=0. All outputs are 0: in_ready, dec_*, out_*, busy, err_count, dec_encoded_data. Reset mid-operation aborts the codeword and drops all strobes on that same edge.
- FSM states: IDLE, LOAD, SHIFT, CHECK, DONE.
  - IDLE: in_ready=1. When in_valid&in_ready, register in_code into dec_encoded_data and go to LOAD.
  - LOAD: one cycle with dec_load=1 and all other strobes 0. Clear the shift counter. Go to SHIFT.
  - SHIFT: dec_shift_en=1 for exactly CODE_WIDTH consecutive cycles; the counter counts 0..CODE_WIDTH-1. After the cycle with count=CODE_WIDTH-1, go to CHECK.
  - CHECK: one cycle with dec_processing_complete=1. At the end of this cycle, latch out_data<=dec_decoded_data and out_error<=dec_error_detected. If the error flag is 1, increment err_count. Go to DONE.
  - DONE: out_valid=1; out_data and out_error are held stable. When out_ready=1, the transfer completes; go to IDLE and out_valid=0 on the next cycle.
- Latency: with the accept at cycle 0, LOAD is at cycle 1, SHIFT at cycles 2..13, CHECK at 14, and out_valid rises at cycle 15 (CODE_WIDTH+3).
- Throughput: at best one codeword per CODE_WIDTH+4 cycles.
- in_ready is 0 in every state except IDLE; in_valid there is ignored and in_code is not sampled.
- No bypass from DONE to IDLE-accept in the same cycle: in_ready rises the cycle after the output transfer.
- out_ready already high when out_valid rises: the transfer completes in that first DONE cycle.
- out_ready low: DONE holds indefinitely and no new codeword is accepted.
- dec_encoded_data holds the last accepted codeword until the next accept.
- At most one of dec_load, dec_shift_en, dec_processing_complete is high in any cycle.
- err_count saturates at 2^ERR_CNT_WIDTH-1.
- err_clr takes priority over an increment in the same cycle (result 0).
- err_clr has no effect on the FSM.
- busy = (state != IDLE).

Test Plan:
- Reset then accept in_code=12'h013 with the decoder returning data 8'h01, error 0:
  - dec_load is high at cycle 1.
  - dec_shift_en is high for exactly 12 cycles (2..13).
  - dec_processing_complete is high at cycle 14.
  - At cycle 15: out_valid=1, out_data=8'h01, out_error=0, err_count=0.
- in_code=12'h0FF4 (valid, data 8'hFF) then 12'hFF5 (decoder error=1):
  - First result: out_error=0.
  - Second result: out_error=1, err_count=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid:
  - out_valid, out_data and out_error stay stable.
  - in_ready=0 throughout, even with in_valid=1.
  - out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next cycle.
- Assert rst during SHIFT (cycle 7):
  - All strobes, busy and err_count are 0 on the next edge.
  - A new codeword 12'h013 is then processed with full cycle-1 latency.
- Saturation with ERR_CNT_WIDTH=2: send 5 erroring codewords -> err_count=3.
  - err_clr coincident with the CHECK of an error word -> err_count=0.
- Back-to-back stream with out_ready tied high and in_valid held: accepts occur every 16 cycles, and no two decoder strobes are ever high together.
